// File: rtl/grey_pkg.sv
// Shared greyscale packing constants and helpers: default widths, packed-word
// field positions, and a constant-friendly clog2 for sizing position counters.
package grey_pkg;

    localparam int GREY_INPUT_WIDTH = 15;
    localparam int GREY_RGB_BITS    = 12;
    localparam int GREY_BITS        = 10;

    // Packed word layout: [14:10] carries five grey bits, [9:0] a redundant copy of grey[11:2].
    localparam int GREY_HI_MSB   = 14;
    localparam int GREY_HI_LSB   = 10;
    localparam int GREY_RED_MSB  = 9;
    localparam int GREY_RED_LSB  = 0;
    localparam int GREY_CHK_MSB  = 9;
    localparam int GREY_CHK_LSB  = 5;

    typedef logic [GREY_INPUT_WIDTH-1:0] grey_word_t;
    typedef logic [GREY_BITS-1:0]        grey10_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic grey10_t grey10_from_words(input grey_word_t w1, input grey_word_t w2);
        return {w1[GREY_HI_MSB:GREY_HI_LSB], w2[GREY_HI_MSB:GREY_HI_LSB]};
    endfunction

    function automatic logic word_pair_mismatch(input grey_word_t w1, input grey_word_t w2);
        return (w1[GREY_RED_MSB:GREY_RED_LSB] != w2[GREY_RED_MSB:GREY_RED_LSB]) ||
               (w1[GREY_HI_MSB:GREY_HI_LSB] != w1[GREY_CHK_MSB:GREY_CHK_LSB]);
    endfunction

endpackage

// File: rtl/grey_unpack_if.sv
// Word-pair input and pixel output stream of grey_unpack; slave is the unpacker,
// master is the upstream source plus downstream sink.
interface grey_unpack_if
    import grey_pkg::*;
#(
    parameter int NUM_COLS     = 640,
    parameter int NUM_ROWS     = 480,
    parameter int NUM_BITS_RGB = GREY_RGB_BITS,
    parameter int INPUT_WIDTH  = GREY_INPUT_WIDTH
);
    localparam int XW = clog2(NUM_COLS);
    localparam int YW = clog2(NUM_ROWS);

    logic [INPUT_WIDTH-1:0]  idata_in1;
    logic [INPUT_WIDTH-1:0]  idata_in2;
    logic                    ivalid;
    logic                    oready;
    logic [NUM_BITS_RGB-1:0] ored_out;
    logic [NUM_BITS_RGB-1:0] ogreen_out;
    logic [NUM_BITS_RGB-1:0] oblue_out;
    logic [XW-1:0]           ox_pos;
    logic [YW-1:0]           oy_pos;
    logic                    ovalid;
    logic                    iready;
    logic                    osof;
    logic                    oeol;

    modport slave (
        input  idata_in1, idata_in2, ivalid, iready,
        output oready, ored_out, ogreen_out, oblue_out,
        output ox_pos, oy_pos, ovalid, osof, oeol
    );

    modport master (
        output idata_in1, idata_in2, ivalid, iready,
        input  oready, ored_out, ogreen_out, oblue_out,
        input  ox_pos, oy_pos, ovalid, osof, oeol
    );

endinterface

// File: rtl/grey_pos_counter.sv
// Raster position of the pixel currently presented; advances once per accepted
// output pixel and wraps at line and frame ends.
module grey_pos_counter
    import grey_pkg::*;
#(
    parameter  int NUM_COLS = 640,
    parameter  int NUM_ROWS = 480,
    localparam int XW       = clog2(NUM_COLS),
    localparam int YW       = clog2(NUM_ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          x_wrap_o,
    output logic          frame_wrap_o
);
    localparam logic [XW-1:0] X_LAST = XW'(NUM_COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(NUM_ROWS - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign x_wrap_o     = (x_q == X_LAST);
    assign frame_wrap_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/grey_unpack.sv
// Rebuilds a 10-bit grey value from a packed word pair and presents it on all three
// colour channels with raster position. Define GREY_UNPACK_CHECK_EN for the oerr check.
module grey_unpack
    import grey_pkg::*;
#(
    parameter int NUM_COLS     = 640,
    parameter int NUM_ROWS     = 480,
    parameter int NUM_BITS_RGB = GREY_RGB_BITS,
    parameter int INPUT_WIDTH  = GREY_INPUT_WIDTH
) (
    input  logic iclk,
    input  logic irst,
    input  logic iclr,
`ifdef GREY_UNPACK_CHECK_EN
    output logic oerr,
`endif
    grey_unpack_if.slave bus
);
    localparam int XW = clog2(NUM_COLS);
    localparam int YW = clog2(NUM_ROWS);

    logic                    in_xfer;
    logic                    out_xfer;
    logic                    ovalid_q, ovalid_d;
    logic [NUM_BITS_RGB-1:0] grey_q, grey_d;
    grey10_t                 grey10;
    logic [XW-1:0]           x_pos;
    logic [YW-1:0]           y_pos;
    logic                    x_wrap;
    logic                    unused_frame_wrap;

    // One-entry output register: a new pair is taken whenever the slot is empty or draining.
    assign bus.oready = !ovalid_q || bus.iready;
    assign in_xfer    = bus.ivalid && bus.oready;
    assign out_xfer   = ovalid_q && bus.iready;
    assign grey10     = grey10_from_words(bus.idata_in1[GREY_INPUT_WIDTH-1:0],
                                          bus.idata_in2[GREY_INPUT_WIDTH-1:0]);

    always_comb begin
        ovalid_d = ovalid_q;
        grey_d   = grey_q;
        if (iclr) begin
            ovalid_d = 1'b0;
        end else if (in_xfer) begin
            ovalid_d = 1'b1;
            grey_d   = NUM_BITS_RGB'(grey10) << (NUM_BITS_RGB - GREY_BITS);
        end else if (out_xfer) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            ovalid_q <= 1'b0;
            grey_q   <= '0;
        end else begin
            ovalid_q <= ovalid_d;
            grey_q   <= grey_d;
        end
    end

    grey_pos_counter #(
        .NUM_COLS (NUM_COLS),
        .NUM_ROWS (NUM_ROWS)
    ) u_pos (
        .clk          (iclk),
        .rst          (irst),
        .clr_i        (iclr),
        .en_i         (out_xfer),
        .x_o          (x_pos),
        .y_o          (y_pos),
        .x_wrap_o     (x_wrap),
        .frame_wrap_o (unused_frame_wrap)
    );

    assign bus.ored_out   = grey_q;
    assign bus.ogreen_out = grey_q;
    assign bus.oblue_out  = grey_q;
    assign bus.ovalid     = ovalid_q;
    assign bus.ox_pos     = x_pos;
    assign bus.oy_pos     = y_pos;
    assign bus.osof       = ovalid_q && (x_pos == '0) && (y_pos == '0);
    assign bus.oeol       = ovalid_q && x_wrap;

`ifdef GREY_UNPACK_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (iclr) begin
            err_d = 1'b0;
        end else if (in_xfer && word_pair_mismatch(bus.idata_in1[GREY_INPUT_WIDTH-1:0],
                                                   bus.idata_in2[GREY_INPUT_WIDTH-1:0])) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign oerr = err_q;
`else
    // The redundant copy is only consumed by the check logic.
    logic unused_redundant;
    assign unused_redundant = ^{bus.idata_in1[GREY_RED_MSB:GREY_RED_LSB],
                                bus.idata_in2[GREY_RED_MSB:GREY_RED_LSB]};
`endif

endmodule

// File: doc/grey_unpack.md
GREY_UNPACK -- requirements
Module: grey_unpack

Interface
REQ-001 SHALL have parameter NUM_COLS, default 640: pixels per line.
REQ-002 SHALL have parameter NUM_ROWS, default 480: lines per frame.
REQ-003 SHALL have parameter NUM_BITS_RGB, default 12: width of each colour output.
REQ-004 SHALL have parameter INPUT_WIDTH, default 15: width of each packed input word.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; clock and reset are the first two ports.
REQ-006 iclk  input  1  sole clock; all state on rising edge.
REQ-007 irst  input  1  asynchronous, active-high reset.
REQ-008 iclr  input  1  synchronous frame resync; clears counters and pipeline.
REQ-009 idata_in1  input  INPUT_WIDTH  packed word 1: [14:10]=grey[11:7], [9:0]=grey[11:2].
REQ-010 idata_in2  input  INPUT_WIDTH  packed word 2: [14:10]=grey[6:2], [9:0]=grey[11:2].
REQ-011 ivalid  input  1  word pair valid.
REQ-012 oready  output  1  block accepts word pair this cycle.
REQ-013 ored_out, ogreen_out, oblue_out  output  NUM_BITS_RGB each  reconstructed grey on all three channels.
REQ-014 ox_pos  output  clog2(NUM_COLS)  column of presented pixel.
REQ-015 oy_pos  output  clog2(NUM_ROWS)  row of presented pixel.
REQ-016 ovalid  output  1  output pixel valid.
REQ-017 iready  input  1  downstream accepts pixel.
REQ-018 osof, oeol  output  1 each  start of frame / end of line, qualified by ovalid.
REQ-019 oerr  output  1  sticky redundancy-mismatch flag (present only with GREY_UNPACK_CHECK_EN).

Function
REQ-020 Input transfer SHALL occur when ivalid && oready; output transfer when ovalid && iready.
REQ-021 oready SHALL equal !ovalid || iready (one-entry output register, full-throughput).
REQ-022 On input transfer, grey10 SHALL be {idata_in1[14:10], idata_in2[14:10]}, and each colour output SHALL be {grey10, 2'b00}, registered; latency exactly 1 cycle.
REQ-023 Output data, position and flags SHALL hold stable while ovalid && !iready.
REQ-024 Position counter SHALL start at (0,0); after each output transfer x increments; at x=NUM_COLS-1 x wraps to 0 and y increments; at (NUM_COLS-1, NUM_ROWS-1) both wrap to 0.
REQ-025 ox_pos/oy_pos SHALL give the counter value of the presented pixel.
REQ-026 osof SHALL be 1 iff ovalid and position is (0,0); oeol SHALL be 1 iff ovalid and x=NUM_COLS-1.
REQ-027 iclr SHALL, next edge, zero counters, clear ovalid and clear oerr; iclr has priority over a simultaneous input or output transfer, whose word is discarded.
REQ-028 With ovalid && iready && ivalid in one cycle, the new pixel SHALL replace the old with no bubble.

Reset
REQ-029 irst SHALL asynchronously force ovalid=0, all colour outputs=0, ox_pos=0, oy_pos=0, oerr=0; osof=oeol=0 follow; oready=1 after reset.
REQ-030 Reset asserted mid-line SHALL drop the held pixel; first pixel after release is (0,0).

Configuration
REQ-031 Macro GREY_UNPACK_CHECK_EN defined: on each input transfer, if idata_in1[9:0] != idata_in2[9:0] or idata_in1[14:10] != idata_in1[9:5], oerr SHALL set and stay set until irst or iclr.
REQ-032 Macro undefined: port oerr and all check logic SHALL be absent; data path unchanged.

Structure
REQ-033 Package grey_pkg SHALL hold clog2 function, default widths (15, 12, 10) and the grey-unpack field-slice constants, shared with the greyscale packer.
REQ-034 Sub-module grey_pos_counter SHALL implement REQ-024 (enable, clear, wrap outputs); all else inline.

Verification
REQ-035 Word pair 0x7FFF/0x7FFF, iready=1 -> next cycle ovalid=1, all colours 0xFFC, (0,0), osof=1.
REQ-036 Stream 640 pairs, iready=1 -> pixel 639 has oeol=1, ox_pos=639; pixel 640 shows (0,1).
REQ-037 Full frame 307200 pixels -> pixel 307200 shows (0,0) with osof=1.
REQ-038 iready=0 for 5 cycles with ivalid=1 -> oready=0, outputs frozen; iready=1 -> one transfer per cycle, no loss/duplication.
REQ-039 iclr at (100,20) with simultaneous transfer -> ovalid=0 next cycle; next pixel (0,0).
REQ-040 Check build: pair 0x0155/0x0154 -> oerr=1, held until iclr; non-check build: same stimulus, no oerr port, colours 0x000.
